// File: rtl/sr_latch_bank.sv
// Bank of independent clocked set/reset cells with glitch filtering,
// selectable both-asserted resolution, change strobes and sticky conflicts.
module sr_latch_bank #(
    parameter int                  CHANNELS = 8,
    parameter int                  MODE     = 0,
    parameter int                  FILTER   = 2,
    parameter logic [CHANNELS-1:0] INIT     = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] set,
    input  logic [CHANNELS-1:0] reset,
    input  logic                conflict_clr,
    output logic [CHANNELS-1:0] q,
    output logic [CHANNELS-1:0] qbar,
    output logic [CHANNELS-1:0] q_changed,
    output logic [CHANNELS-1:0] conflict
);

    localparam int            CW   = (FILTER < 1) ? 1 : $clog2(FILTER + 1);
    localparam logic [CW-1:0] FMAX = CW'(FILTER);

    genvar g;
    for (g = 0; g < CHANNELS; g++) begin : g_ch
        logic [1:0]    p_q;
        logic [1:0]    pair;
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic          fired_q;
        logic          fired_d;
        logic          q_q;
        logic          q_d;
        logic          qbar_q;
        logic          chg_q;
        logic          conf_q;
        logic          conf_d;
        logic          same;
        logic          qual;

        assign pair = {set[g], reset[g]};
        assign same = (pair == p_q);
        // The acting edge itself must still see the same pair
        assign qual = same && (cnt_q == FMAX);

        always_comb begin
            cnt_d = '0;
            if (same) begin
                cnt_d = (cnt_q == FMAX) ? cnt_q : cnt_q + 1'b1;
            end
            fired_d = same && (fired_q || qual);
            q_d     = q_q;
            if (qual) begin
                unique case (p_q)
                    2'b10: q_d = 1'b1;
                    2'b01: q_d = 1'b0;
                    2'b11: begin
                        if (MODE == 0) begin
                            q_d = 1'b0;
                        end else if (MODE == 1) begin
                            q_d = 1'b1;
                        end else if (MODE == 3 && !fired_q) begin
                            q_d = ~q_q;
                        end
                    end
                    default: q_d = q_q;
                endcase
            end
            conf_d = (qual && (p_q == 2'b11)) || (conf_q && !conflict_clr);
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                p_q     <= 2'b00;
                cnt_q   <= '0;
                fired_q <= 1'b1;
                q_q     <= INIT[g];
                qbar_q  <= ~INIT[g];
                chg_q   <= 1'b0;
                conf_q  <= 1'b0;
            end else begin
                p_q     <= pair;
                cnt_q   <= cnt_d;
                fired_q <= fired_d;
                q_q     <= q_d;
                qbar_q  <= ~q_d;
                chg_q   <= (q_d != q_q);
                conf_q  <= conf_d;
            end
        end

        assign q[g]         = q_q;
        assign qbar[g]      = qbar_q;
        assign q_changed[g] = chg_q;
        assign conflict[g]  = conf_q;
    end

endmodule

// File: tb/tb_sr_latch_bank.sv
// Randomised and directed bench for sr_latch_bank, one instance per
// resolution mode, all compared against a run-length reference model.
module tb_sr_latch_bank;

    localparam int         FILT = 2;
    localparam logic [7:0] INIT = 8'hA5;

    logic       clk;
    logic       rst_n;
    logic [7:0] set_i;
    logic [7:0] reset_i;
    logic       clr;
    logic [7:0] dq[4];
    logic [7:0] dqb[4];
    logic [7:0] dchg[4];
    logic [7:0] dcf[4];

    logic [7:0] mq[4];
    logic [7:0] mchg[4];
    logic [7:0] mcf[4];
    int         run[8];
    logic [1:0] last[8];

    int n_tests;
    int n_fail;

    sr_latch_bank #(.CHANNELS(8), .MODE(0), .FILTER(FILT), .INIT(INIT)) u_m0 (
        .clk(clk), .rst_n(rst_n), .set(set_i), .reset(reset_i),
        .conflict_clr(clr), .q(dq[0]), .qbar(dqb[0]),
        .q_changed(dchg[0]), .conflict(dcf[0])
    );
    sr_latch_bank #(.CHANNELS(8), .MODE(1), .FILTER(FILT), .INIT(INIT)) u_m1 (
        .clk(clk), .rst_n(rst_n), .set(set_i), .reset(reset_i),
        .conflict_clr(clr), .q(dq[1]), .qbar(dqb[1]),
        .q_changed(dchg[1]), .conflict(dcf[1])
    );
    sr_latch_bank #(.CHANNELS(8), .MODE(2), .FILTER(FILT), .INIT(INIT)) u_m2 (
        .clk(clk), .rst_n(rst_n), .set(set_i), .reset(reset_i),
        .conflict_clr(clr), .q(dq[2]), .qbar(dqb[2]),
        .q_changed(dchg[2]), .conflict(dcf[2])
    );
    sr_latch_bank #(.CHANNELS(8), .MODE(3), .FILTER(FILT), .INIT(INIT)) u_m3 (
        .clk(clk), .rst_n(rst_n), .set(set_i), .reset(reset_i),
        .conflict_clr(clr), .q(dq[3]), .qbar(dqb[3]),
        .q_changed(dchg[3]), .conflict(dcf[3])
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // A pair acts once it has been seen on FILT+2 consecutive edges;
    // toggle mode acts only on the first such edge of a run.
    task automatic model_step(input logic [7:0] s, input logic [7:0] r,
                              input logic c, input logic rn);
        logic [1:0] pr;
        logic       act;
        logic       oq;
        logic       nq;
        if (!rn) begin
            for (int m = 0; m < 4; m++) begin
                mq[m]   = INIT;
                mchg[m] = 8'h00;
                mcf[m]  = 8'h00;
            end
            for (int ch = 0; ch < 8; ch++) begin
                last[ch] = 2'b00;
                run[ch]  = 1;
            end
        end else begin
            for (int ch = 0; ch < 8; ch++) begin
                pr = {s[ch], r[ch]};
                if (pr == last[ch]) begin
                    if (run[ch] < 1000) run[ch]++;
                end else begin
                    last[ch] = pr;
                    run[ch]  = 1;
                end
                act = (run[ch] >= FILT + 2);
                for (int m = 0; m < 4; m++) begin
                    oq = mq[m][ch];
                    nq = oq;
                    if (act) begin
                        if (pr == 2'b10) nq = 1'b1;
                        else if (pr == 2'b01) nq = 1'b0;
                        else if (pr == 2'b11) begin
                            if (m == 0) nq = 1'b0;
                            else if (m == 1) nq = 1'b1;
                            else if (m == 3 && run[ch] == FILT + 2) nq = ~oq;
                        end
                    end
                    mq[m][ch]   = nq;
                    mchg[m][ch] = (nq != oq);
                    if (act && pr == 2'b11) mcf[m][ch] = 1'b1;
                    else if (c) mcf[m][ch] = 1'b0;
                end
            end
        end
    endtask

    task automatic step(input logic [7:0] s, input logic [7:0] r,
                        input logic c, input logic rn);
        set_i   = s;
        reset_i = r;
        clr     = c;
        rst_n   = rn;
        @(posedge clk);
        #1;
        model_step(s, r, c, rn);
        for (int m = 0; m < 4; m++) begin
            check($sformatf("m%0d_q", m), dq[m], mq[m]);
            check($sformatf("m%0d_qbar", m), dqb[m], ~mq[m]);
            check($sformatf("m%0d_chg", m), dchg[m], mchg[m]);
            check($sformatf("m%0d_conf", m), dcf[m], mcf[m]);
        end
    endtask

    initial begin
        logic [7:0] cs;
        logic [7:0] cr;
        int         pulses;
        n_tests = 0;
        n_fail  = 0;
        clk     = 1'b0;
        rst_n   = 1'b0;
        set_i   = 8'h00;
        reset_i = 8'h00;
        clr     = 1'b0;

        repeat (2) step(8'($urandom), 8'($urandom), 1'b0, 1'b0);
        check("rst_q", dq[0], 8'hA5);
        check("rst_qbar", dqb[0], 8'h5A);
        check("rst_chg", dchg[0], 8'h00);
        check("rst_conf", dcf[0], 8'h00);

        // Filter: drive ch0 low, then a short and a qualifying set pulse
        repeat (4) step(8'h00, 8'h01, 1'b0, 1'b1);
        repeat (2) step(8'h00, 8'h00, 1'b0, 1'b1);
        repeat (3) step(8'h01, 8'h00, 1'b0, 1'b1);
        repeat (3) begin
            step(8'h00, 8'h00, 1'b0, 1'b1);
            check("flt_short", 8'(dq[0][0]), 8'd0);
        end
        for (int k = 0; k < 4; k++) begin
            step(8'h01, 8'h00, 1'b0, 1'b1);
            check("flt_q", 8'(dq[0][0]), 8'(k == 3));
            check("flt_chg", 8'(dchg[0][0]), 8'(k == 3));
        end
        step(8'h00, 8'h00, 1'b0, 1'b1);
        check("flt_chg_end", 8'(dchg[0][0]), 8'd0);

        // Conflict under reset-dominant resolution on ch3
        repeat (4) step(8'h08, 8'h00, 1'b0, 1'b1);
        check("cf_pre_q", 8'(dq[0][3]), 8'd1);
        repeat (4) step(8'h08, 8'h08, 1'b0, 1'b1);
        check("cf_q", 8'(dq[0][3]), 8'd0);
        check("cf_set", 8'(dcf[0][3]), 8'd1);
        step(8'h08, 8'h08, 1'b1, 1'b1);
        check("cf_clr_held", 8'(dcf[0][3]), 8'd1);
        step(8'h00, 8'h00, 1'b0, 1'b1);
        step(8'h00, 8'h00, 1'b1, 1'b1);
        check("cf_clr", 8'(dcf[0][3]), 8'd0);

        // Toggle-once on ch1
        pulses = 0;
        repeat (10) begin
            step(8'h02, 8'h02, 1'b0, 1'b1);
            pulses += int'(dchg[3][1]);
        end
        check("tog_pulses", 8'(pulses), 8'd1);
        check("tog_q", 8'(dq[3][1]), 8'd1);
        repeat (3) step(8'h00, 8'h00, 1'b0, 1'b1);
        pulses = 0;
        repeat (FILT + 2) begin
            step(8'h02, 8'h02, 1'b0, 1'b1);
            pulses += int'(dchg[3][1]);
        end
        check("tog2_pulses", 8'(pulses), 8'd1);
        check("tog2_q", 8'(dq[3][1]), 8'd0);

        // Reset in the middle of a filter window on ch2/ch3
        step(8'h0C, 8'h00, 1'b0, 1'b1);
        step(8'h0C, 8'h00, 1'b0, 1'b0);
        check("mid_q3", 8'(dq[0][3]), 8'd0);
        check("mid_q2", 8'(dq[0][2]), 8'd1);
        check("mid_chg", dchg[0], 8'h00);
        for (int k = 0; k < FILT + 2; k++) begin
            step(8'h0C, 8'h00, 1'b0, 1'b1);
            check("mid_rise", 8'(dq[0][3]), 8'(k == FILT + 1));
            check("mid_rise_chg", 8'(dchg[0][3]), 8'(k == FILT + 1));
        end

        // Simultaneous events on independent channels, set-dominant
        repeat (4) step(8'h02, 8'h81, 1'b0, 1'b1);
        repeat (2) step(8'h00, 8'h00, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(8'h81, 8'h82, 1'b0, 1'b1);
            if (k == 2) check("ind_pre", dq[1] & 8'h83, 8'h02);
        end
        check("ind_q", dq[1] & 8'h83, 8'h81);
        check("ind_chg", dchg[1] & 8'h83, 8'h83);
        check("ind_conf", dcf[1], 8'h80);

        // Random held-level stimulus with occasional clears and resets
        cs = 8'h00;
        cr = 8'h00;
        repeat (400) begin
            cs ^= 8'($urandom) & 8'($urandom) & 8'($urandom);
            cr ^= 8'($urandom) & 8'($urandom) & 8'($urandom);
            step(cs, cr, 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 49) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
